keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 5000: clk cycles each column is driven while scanning; legal minimum 4.
REQ-002 Parameter DEBOUNCE_CNT, default 100000: consecutive stable cycles required to accept a press and to accept a release; legal minimum 2.
REQ-003 clk  input  1: single system clock; all logic on the rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 row  input  4: keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 col  output 4: keypad column drive, active-low, exactly one bit low at all times.
REQ-007 selC  output 3: column index of the accepted key, 0..3, zero-extended.
REQ-008 selF  output 3: row index of the accepted key, 0..3, zero-extended.
REQ-009 enable  output 1: one-cycle strobe marking a newly accepted key; this port feeds the display data-control selC/selF/enable inputs.
REQ-010 pressed  output 1: level, high from acceptance until release is accepted.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer; all decisions below use the synchronized value rs.
REQ-012 Column index c drives col: c=0 -> 1110, c=1 -> 1101, c=2 -> 1011, c=3 -> 0111.
REQ-013 The FSM SHALL have the states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-014 SCAN: divider counts 0..SCAN_DIV-1; at SCAN_DIV-1, c advances modulo 4 (3 wraps to 0) and the divider clears.
REQ-015 SCAN: rs is ignored while divider < 2 (settling window after a column change).
REQ-016 SCAN: with divider >= 2 and any rs bit low, capture row index r (lowest-index low bit wins when several are low), freeze c, clear the debounce counter, and go to DEBOUNCE.
REQ-017 DEBOUNCE: each cycle rs[r] is low, the counter increments; on the cycle the counter equals DEBOUNCE_CNT-1: load selC<=c and selF<=r, pulse enable for exactly that one cycle, set pressed, and go to HELD.
REQ-018 DEBOUNCE: if rs[r] goes high, return to SCAN with the same c, divider cleared, and no output change.
REQ-019 HELD: c stays frozen; when all 4 rs bits are high, clear the counter and go to RELEASE.
REQ-020 RELEASE: the counter increments each cycle all rs bits are high.
REQ-021 RELEASE, counter at DEBOUNCE_CNT-1: clear pressed, advance c by one (mod 4), clear the divider, and go to SCAN.
REQ-022 RELEASE: if any rs bit goes low, return to HELD; enable is not pulsed and selC/selF are unchanged.
REQ-023 Only one enable pulse is produced per accepted press, regardless of hold duration.
REQ-024 Other keys pressed while in HELD are ignored until the release is accepted.
REQ-025 selC/selF retain the last accepted key until the next accepted key.
REQ-026 Counters SHALL be sized by $clog2 of their parameter and SHALL never wrap while in DEBOUNCE or RELEASE.

Reset
REQ-027 When rst is low, outputs SHALL immediately take these values: col=1110, selC=0, selF=0, enable=0, pressed=0. The state is SCAN, c=0, and all counters and synchronizer flops are cleared to "all rows high".
REQ-028 Reset asserted mid-operation (any state) SHALL abort without producing an enable pulse.
REQ-029 Reset deassertion is synchronized by the integrator; the first clk edge after release begins SCAN with c=0.

Verification
Bench uses SCAN_DIV=4, DEBOUNCE_CNT=8.
REQ-030 Idle, row=1111 for 64 cycles -> col cycles 1110, 1101, 1011, 0111, 1110 with each value held 4 cycles; enable stays 0.
REQ-031 Clean press: row=1011 while col=1101, held 40 cycles -> one enable pulse, selC=1, selF=2, pressed=1; after row=1111 for 8 cycles, pressed=0 and scanning resumes with col=1011.
REQ-032 Bouncy press: row[0] toggles every 3 cycles for 30 cycles, then stays low 20 cycles -> no enable during the bounce, exactly one enable afterwards, selF=0.
REQ-033 Bouncy release: in HELD, rows go high for 5 cycles, then low, then high for 10 cycles -> pressed stays 1 until the last 8-cycle high run, and no extra enable occurs.
REQ-034 Multi-row: row=0101 on column 3 -> selF=1 and selC=3.
REQ-035 Reset mid-DEBOUNCE: rst low at counter=5 -> immediately col=1110 and enable=0 with no pulse; after release, normal scanning resumes.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks an active-low column drive, debounces press and
// release of one key, and strobes the accepted column/row index.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 5000,
    parameter int unsigned DEBOUNCE_CNT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [2:0] selC,
    output logic [2:0] selF,
    output logic       enable,
    output logic       pressed
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIV_SETTLE = DW'(2);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    row_meta_q, rs_q;
    logic [1:0]    c_q, c_d;
    logic [1:0]    r_q, r_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_c_q, sel_c_d;
    logic [1:0]    sel_f_q, sel_f_d;
    logic          enable_q, enable_d;
    logic          pressed_q, pressed_d;
    logic [1:0]    low_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SCAN;
            row_meta_q <= '1;
            rs_q       <= '1;
            c_q        <= '0;
            r_q        <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            sel_c_q    <= '0;
            sel_f_q    <= '0;
            enable_q   <= 1'b0;
            pressed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_meta_q <= row;
            rs_q       <= row_meta_q;
            c_q        <= c_d;
            r_q        <= r_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            sel_c_q    <= sel_c_d;
            sel_f_q    <= sel_f_d;
            enable_q   <= enable_d;
            pressed_q  <= pressed_d;
        end
    end

    // Lowest-numbered low row wins when several rows are pulled low together.
    always_comb begin
        if (!rs_q[0])      low_idx = 2'd0;
        else if (!rs_q[1]) low_idx = 2'd1;
        else if (!rs_q[2]) low_idx = 2'd2;
        else               low_idx = 2'd3;
    end

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        r_d       = r_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        sel_c_d   = sel_c_q;
        sel_f_d   = sel_f_q;
        enable_d  = 1'b0;
        pressed_d = pressed_q;
        case (state_q)
            SCAN: begin
                if (div_q >= DIV_SETTLE && rs_q != '1) begin
                    r_d     = low_idx;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    c_d   = c_q + 2'd1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs_q[r_q]) begin
                    div_d   = '0;
                    state_d = SCAN;
                end else if (cnt_q == CNT_LAST) begin
                    sel_c_d   = c_q;
                    sel_f_d   = r_q;
                    enable_d  = 1'b1;
                    pressed_d = 1'b1;
                    state_d   = HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (rs_q == '1) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (rs_q != '1) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    pressed_d = 1'b0;
                    c_d       = c_q + 2'd1;
                    div_d     = '0;
                    state_d   = SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        col     = ~(4'b0001 << c_q);
        selC    = {1'b0, sel_c_q};
        selF    = {1'b0, sel_f_q};
        enable  = enable_q;
        pressed = pressed_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model pulls rows low only
// while the pressed key's column is driven; accepted keys go through a queue.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [2:0] selC, selF;
    logic       enable, pressed;

    logic       key_down;
    logic [1:0] key_c;
    logic [3:0] key_rows;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] c;
        logic [2:0] f;
    } exp_t;
    exp_t exp_q[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .selC(selC), .selF(selF), .enable(enable), .pressed(pressed)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] colcode(input logic [1:0] c);
        case (c)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    always_comb begin
        row = 4'hF;
        if (key_down && col == colcode(key_c)) row = ~key_rows;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_enable got selC=%0d selF=%0d, expected no strobe", selC, selF);
            end else begin
                e = exp_q.pop_front();
                if (selC !== e.c || selF !== e.f) begin
                    errors++;
                    $display("FAIL enable_payload got selC=%0d selF=%0d, expected selC=%0d selF=%0d",
                             selC, selF, e.c, e.f);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [1:0] c);
        int n = 0;
        while (col === colcode(c) && n < 64) begin tick(1); n++; end
        while (col !== colcode(c) && n < 64) begin tick(1); n++; end
        checks++;
        if (col !== colcode(c)) begin
            errors++;
            $display("FAIL wait_col timeout col=%b expected %b", col, colcode(c));
        end
    endtask

    task automatic press(input logic [1:0] c, input logic [3:0] rows);
        wait_col(c);
        key_c    = c;
        key_rows = rows;
        key_down = 1'b1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing enable, %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (col !== 4'b1110 || selC !== 3'd0 || selF !== 3'd0 || enable !== 1'b0 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL reset_values col=%b selC=%0d selF=%0d en=%b pr=%b expected 1110 0 0 0 0",
                     col, selC, selF, enable, pressed);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_idle;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (col !== colcode(2'(k / 4))) begin
                errors++;
                $display("FAIL idle_col cycle %0d got %b expected %b", k, col, colcode(2'(k / 4)));
            end
            tick(1);
        end
        check_drained("idle");
    endtask

    task automatic test_clean_press;
        press(2'd1, 4'b0100);
        exp_q.push_back('{3'd1, 3'd2});
        tick(10);
        checks++;
        if (pressed !== 1'b0) begin errors++; $display("FAIL press_early got %b expected 0", pressed); end
        tick(1);
        checks++;
        if (pressed !== 1'b1 || enable !== 1'b1) begin
            errors++; $display("FAIL press_accept pr=%b en=%b expected 1 1", pressed, enable);
        end
        tick(1);
        checks++;
        if (enable !== 1'b0) begin errors++; $display("FAIL enable_width got %b expected 0", enable); end
        tick(38);
        checks++;
        if (pressed !== 1'b1 || selC !== 3'd1 || selF !== 3'd2) begin
            errors++; $display("FAIL press_hold pr=%b selC=%0d selF=%0d expected 1 1 2", pressed, selC, selF);
        end
        key_down = 1'b0;
        tick(10);
        checks++;
        if (pressed !== 1'b1) begin errors++; $display("FAIL release_early got %b expected 1", pressed); end
        tick(1);
        checks++;
        if (pressed !== 1'b0 || col !== 4'b1011) begin
            errors++; $display("FAIL release_resume pr=%b col=%b expected 0 1011", pressed, col);
        end
        check_drained("clean_press");
    endtask

    task automatic test_bouncy_press;
        key_c    = 2'd0;
        key_rows = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            key_down = (i % 2 == 0);
            tick(3);
        end
        key_down = 1'b1;
        exp_q.push_back('{3'd0, 3'd0});
        tick(40);
        checks++;
        if (pressed !== 1'b1 || selC !== 3'd0 || selF !== 3'd0) begin
            errors++; $display("FAIL bouncy_press pr=%b selC=%0d selF=%0d expected 1 0 0", pressed, selC, selF);
        end
        key_down = 1'b0;
        tick(15);
        checks++;
        if (pressed !== 1'b0) begin errors++; $display("FAIL bouncy_press_release got %b expected 0", pressed); end
        check_drained("bouncy_press");
    endtask

    task automatic test_bouncy_release;
        press(2'd2, 4'b1000);
        exp_q.push_back('{3'd2, 3'd3});
        tick(20);
        key_down = 1'b0;
        tick(5);
        key_down = 1'b1;
        tick(4);
        checks++;
        if (pressed !== 1'b1) begin errors++; $display("FAIL bounce_release_short got %b expected 1", pressed); end
        key_down = 1'b0;
        tick(10);
        checks++;
        if (pressed !== 1'b1) begin errors++; $display("FAIL bounce_release_late got %b expected 1", pressed); end
        tick(1);
        checks++;
        if (pressed !== 1'b0) begin errors++; $display("FAIL bounce_release_done got %b expected 0", pressed); end
        check_drained("bouncy_release");
    endtask

    task automatic test_multi_row;
        press(2'd3, 4'b1010);
        exp_q.push_back('{3'd3, 3'd1});
        tick(12);
        checks++;
        if (pressed !== 1'b1 || selC !== 3'd3 || selF !== 3'd1) begin
            errors++; $display("FAIL multi_row pr=%b selC=%0d selF=%0d expected 1 3 1", pressed, selC, selF);
        end
        key_down = 1'b0;
        tick(12);
        checks++;
        if (pressed !== 1'b0) begin errors++; $display("FAIL multi_row_release got %b expected 0", pressed); end
        check_drained("multi_row");
    endtask

    task automatic test_reset_mid_debounce;
        press(2'd0, 4'b0010);
        tick(8);
        rst = 1'b0;
        #1;
        checks++;
        if (col !== 4'b1110 || enable !== 1'b0 || pressed !== 1'b0 || selC !== 3'd0 || selF !== 3'd0) begin
            errors++;
            $display("FAIL reset_abort col=%b en=%b pr=%b selC=%0d selF=%0d expected 1110 0 0 0 0",
                     col, enable, pressed, selC, selF);
        end
        key_down = 1'b0;
        tick(3);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (col !== colcode(2'(k / 4)) || pressed !== 1'b0) begin
                errors++;
                $display("FAIL reset_resume cycle %0d col=%b pr=%b expected %b 0", k, col, pressed, colcode(2'(k / 4)));
            end
            tick(1);
        end
        check_drained("reset_mid_debounce");
    endtask

    initial begin
        rst      = 1'b0;
        key_down = 1'b0;
        key_c    = 2'd0;
        key_rows = 4'b0000;
        tick(3);
        test_reset;
        test_idle;
        test_clean_press;
        test_bouncy_press;
        test_bouncy_release;
        test_multi_row;
        test_reset_mid_debounce;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
